jb_aes_ctr_stream: RTL and testbench

//  AES counter-mode (CTR) stream engine that keeps a fixed-latency, non-stalling AES encrypt pipe fully busy.

---
 rtl/jb_aes_ctr_stream.sv | 157 +++++++++++++++
 tb/tb_jb_aes_ctr_stream.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jb_aes_ctr_stream.sv
// AES-CTR stream engine: drives a fixed-latency encrypt pipe with counter blocks, aligns payload
// beats with the returning keystream and buffers the XOR result in a credit-protected output FIFO.
module jb_aes_ctr_stream #(
  parameter int BLOCK_WIDTH  = 128,
  parameter int CORE_LATENCY = 10,
  parameter int FIFO_DEPTH   = 16,
  parameter int CTR_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [BLOCK_WIDTH-1:0] key,
  input  logic [BLOCK_WIDTH-1:0] iv,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BLOCK_WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BLOCK_WIDTH-1:0] out_data,
  output logic                   ctr_wrap,
  output logic [BLOCK_WIDTH-1:0] core_key,
  output logic [BLOCK_WIDTH-1:0] core_blockin,
  input  logic [BLOCK_WIDTH-1:0] core_blockout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int INF_W = $clog2(CORE_LATENCY + 1);
  localparam int SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_next;
  logic   armed;

  logic [BLOCK_WIDTH-1:0] key_reg;
  logic [BLOCK_WIDTH-1:0] ctr;

  logic [CORE_LATENCY-1:0] dly_valid;
  logic [BLOCK_WIDTH-1:0]  dly_data [CORE_LATENCY];
  logic [INF_W-1:0]        inflight;

  logic [BLOCK_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wptr, rptr, head_ptr;
  logic [CNT_W-1:0]       count, count_left;
  logic [SUM_W-1:0]       used;

  logic accept, push, pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (state == IDLE && load) begin
      state_next = RUN;
    end
  end

  always_comb begin
    armed = (state == RUN);
  end

  // Credit covers beats still in the pipe plus beats already buffered, so every exit has a slot.
  assign used     = SUM_W'(inflight) + SUM_W'(count);
  assign in_ready = armed & ~load & (used < SUM_W'(FIFO_DEPTH));

  assign accept = in_valid & in_ready;
  assign push   = dly_valid[CORE_LATENCY-1];
  assign pop    = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_reg  <= '0;
      ctr      <= '0;
      ctr_wrap <= 1'b0;
    end else if (load) begin
      key_reg  <= key;
      ctr      <= iv;
      ctr_wrap <= 1'b0;
    end else if (accept) begin
      ctr[CTR_WIDTH-1:0] <= ctr[CTR_WIDTH-1:0] + CTR_WIDTH'(1);
      if (&ctr[CTR_WIDTH-1:0]) begin
        ctr_wrap <= 1'b1;
      end
    end
  end

  assign core_key     = key_reg;
  assign core_blockin = ctr;

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_valid <= '0;
      inflight  <= '0;
    end else begin
      dly_valid[0] <= accept;
      for (int i = 1; i < CORE_LATENCY; i++) begin
        dly_valid[i] <= dly_valid[i-1];
      end
      if (accept && !push) begin
        inflight <= inflight + INF_W'(1);
      end else if (!accept && push) begin
        inflight <= inflight - INF_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    dly_data[0] <= in_data;
    for (int i = 1; i < CORE_LATENCY; i++) begin
      dly_data[i] <= dly_data[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wptr] <= dly_data[CORE_LATENCY-1] ^ core_blockout;
    end
  end

  // The output register reloads from the entry that will be at the head after this edge's pop.
  assign count_left = count - CNT_W'(pop);
  assign head_ptr   = rptr + PTR_W'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && pop) begin
        count <= count - CNT_W'(1);
      end
      out_valid <= (count_left != '0);
      if (count_left != '0) begin
        out_data <= mem[head_ptr];
      end
    end
  end

endmodule

// File: tb/tb_jb_aes_ctr_stream.sv
// Bench for jb_aes_ctr_stream: real AES-128 pipe model, queue-based reference of the CTR stream,
// directed scenarios from the FIPS vectors plus a randomized phase.
module tb_jb_aes_ctr_stream;

  localparam int BW    = 128;
  localparam int L     = 10;
  localparam int DEPTH = 16;
  localparam int CW    = 32;

  localparam logic [BW-1:0] K_F51  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [BW-1:0] IV_F51 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [BW-1:0] P1     = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [BW-1:0] P2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [BW-1:0] C1     = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [BW-1:0] C2     = 128'h9806f66b7970fdff8617187bb9fffdff;

  logic          clk = 1'b0;
  logic          rst, load, in_valid, out_ready;
  logic          in_ready, out_valid, ctr_wrap;
  logic [BW-1:0] key, iv, in_data, out_data, core_key, core_blockin, core_blockout;

  jb_aes_ctr_stream #(
    .BLOCK_WIDTH (BW),
    .CORE_LATENCY(L),
    .FIFO_DEPTH  (DEPTH),
    .CTR_WIDTH   (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .key          (key),
    .iv           (iv),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .ctr_wrap     (ctr_wrap),
    .core_key     (core_key),
    .core_blockin (core_blockin),
    .core_blockout(core_blockout)
  );

  initial forever #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [7:0] sbt [256];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [BW-1:0] aes(input logic [BW-1:0] k, input logic [BW-1:0] pt);
    logic [31:0]   w [44];
    logic [7:0]    s [16];
    logic [7:0]    t [16];
    logic [31:0]   tmp;
    logic [7:0]    rc, a0, a1, a2, a3;
    logic [BW-1:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]], sbt[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbt[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[row+4*c] = t[row+4*((c+row)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [BW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Non-stalling encrypt pipe: result for the block sampled at edge t is on core_blockout before edge t+L.
  logic [BW-1:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= aes(core_key, core_blockin);
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end
  assign core_blockout = pipe[L-1];

  task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference stream: every accepted beat is owed out in order as data ^ AES(key, counter).
  typedef struct {
    logic [BW-1:0] data;
    int            acc;
  } exp_t;

  exp_t          q[$];
  exp_t          e;
  logic [BW-1:0] m_key, m_ctr;
  logic          m_wrap, m_armed, chk_en = 1'b0, exp_valid;

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("core_key", core_key, m_key);
      checkOutput("core_blockin", core_blockin, m_ctr);
      checkOutput("ctr_wrap", 128'(ctr_wrap), 128'(m_wrap));
      checkOutput("in_ready", 128'(in_ready), 128'(m_armed && !load && q.size() < DEPTH));
      exp_valid = 1'b0;
      if (q.size() > 0) exp_valid = (cyc - q[0].acc >= L + 1);
      checkOutput("out_valid", 128'(out_valid), 128'(exp_valid));
      if (out_valid && q.size() > 0) checkOutput("out_data", out_data, q[0].data);
    end
    if (rst) begin
      q.delete();
      m_key   = '0;
      m_ctr   = '0;
      m_wrap  = 1'b0;
      m_armed = 1'b0;
      chk_en  = 1'b1;
    end else if (chk_en) begin
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (load) begin
        m_key   = key;
        m_ctr   = iv;
        m_wrap  = 1'b0;
        m_armed = 1'b1;
      end else if (in_valid && in_ready) begin
        e.data = in_data ^ aes(m_key, m_ctr);
        e.acc  = cyc + 1;
        q.push_back(e);
        if (&m_ctr[CW-1:0]) m_wrap = 1'b1;
        m_ctr[CW-1:0] = m_ctr[CW-1:0] + 32'd1;
      end
    end
  end

  task automatic applyStimulus(input logic ld, input logic vld, input logic [BW-1:0] d, input logic ordy);
    @(posedge clk);
    #1;
    load      = ld;
    in_valid  = vld;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, ordy);
  endtask

  task automatic waitOut(input string name);
    int i;
    i = 0;
    @(negedge clk);
    while (!out_valid && i < 64) begin
      @(negedge clk);
      i++;
    end
    if (!out_valid) checkOutput(name, 128'(out_valid), 128'(1));
  endtask

  int            acc_cnt, pop_cnt, seen;
  logic [BW-1:0] v;

  initial begin
    logic [7:0] inv;
    rst = 1'b1; load = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; key = '0; iv = '0;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(x));
      sbt[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    checkOutput("model_f51_blk1", aes(K_F51, IV_F51) ^ P1, C1);
    checkOutput("model_f51_blk2", aes(K_F51, {IV_F51[127:32], 32'hfcfdff00}) ^ P2, C2);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_out_data", out_data, '0);
    checkOutput("rst_in_ready", 128'(in_ready), 128'(0));
    checkOutput("rst_blockin", core_blockin, '0);

    // F.5.1 encrypt, then decrypt of the same ciphertexts after a reload
    key = K_F51; iv = IV_F51;
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, P1, 1'b1);
    @(negedge clk);
    checkOutput("f51_blockin1", core_blockin, IV_F51);
    applyStimulus(1'b0, 1'b1, P2, 1'b1);
    @(negedge clk);
    checkOutput("f51_blockin2", core_blockin, {IV_F51[127:32], 32'hfcfdff00});
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    waitOut("f51_timeout");
    checkOutput("f51_out1", out_data, C1);
    @(negedge clk);
    checkOutput("f51_out2", out_data, C2);
    idle(3, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, C1, 1'b1);
    applyStimulus(1'b0, 1'b1, C2, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    waitOut("dec_timeout");
    checkOutput("dec_out1", out_data, P1);
    @(negedge clk);
    checkOutput("dec_out2", out_data, P2);
    idle(4, 1'b1);

    // Backpressure: only FIFO_DEPTH beats are taken, then all drain in order
    acc_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b1, rnd128(), 1'b0);
      @(negedge clk);
      if (in_ready) acc_cnt++;
    end
    checkOutput("fill_count", 128'(acc_cnt), 128'(DEPTH));
    checkOutput("full_in_ready", 128'(in_ready), 128'(0));
    pop_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      if (out_valid) pop_cnt++;
    end
    checkOutput("drain_count", 128'(pop_cnt), 128'(DEPTH));

    // Counter wrap of the low CTR_WIDTH bits
    key = rnd128(); v = rnd128(); iv = {v[127:32], 32'hffffffff};
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, rnd128(), 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("wrap_blockin", core_blockin, {v[127:32], 32'h0});
    checkOutput("wrap_flag", 128'(ctr_wrap), 128'(1));
    iv = rnd128();
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("wrap_cleared", 128'(ctr_wrap), 128'(0));
    idle(L + 4, 1'b1);

    // Re-key with 5 beats in flight
    key = rnd128(); iv = rnd128();
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, rnd128(), 1'b1);
    key = rnd128(); v = rnd128(); iv = v;
    applyStimulus(1'b1, 1'b1, rnd128(), 1'b1);
    @(negedge clk);
    checkOutput("load_in_ready", 128'(in_ready), 128'(0));
    applyStimulus(1'b0, 1'b1, rnd128(), 1'b1);
    @(negedge clk);
    checkOutput("rekey_blockin", core_blockin, v);
    checkOutput("rekey_in_ready", 128'(in_ready), 128'(1));
    idle(L + 6, 1'b1);

    // Reset with the FIFO half full and beats in flight
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, rnd128(), 1'b0);
    idle(L + 4, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, rnd128(), 1'b0);
    @(posedge clk);
    #1 rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("midrst_in_ready", 128'(in_ready), 128'(0));
    key = rnd128(); iv = rnd128();
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("no_stale_beats", 128'(seen), 128'(0));

    // Randomized traffic with occasional re-keys near the wrap point and rare resets
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk);
      #1;
      rst  = ($urandom_range(0, 499) == 0);
      load = ($urandom_range(0, 59) == 0);
      if (load) begin
        key = rnd128();
        iv  = rnd128();
        if ($urandom_range(0, 1) == 1) iv[31:0] = 32'hffffffff - $urandom_range(0, 20);
      end
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = rnd128();
      out_ready = ($urandom_range(0, 9) < 6);
    end
    @(posedge clk);
    #1 rst = 1'b0; load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    idle(L + DEPTH + 10, 1'b1);
    @(negedge clk);
    checkOutput("final_drained", 128'(q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
